// File: rtl/rab_miss_pkg.sv
// Shared types and constants for the RAB miss arbiter: entry layout, widths,
// and the round-robin index helper.
package rab_miss_pkg;

  localparam int N_PORTS        = 3;
  localparam int C_AXI_ID_WIDTH = 8;
  localparam int PORT_ID_WIDTH  = 2;
  localparam int FIFO_DEPTH     = 4;
  localparam int ADDR_WIDTH     = 32;
  localparam int PTR_WIDTH      = $clog2(FIFO_DEPTH);
  localparam int CNT_WIDTH      = PTR_WIDTH + 1;

  typedef logic [PORT_ID_WIDTH-1:0] port_idx_t;

  typedef struct packed {
    port_idx_t                 port;
    logic [C_AXI_ID_WIDTH-1:0] id;
    logic [ADDR_WIDTH-1:0]     addr;
  } miss_entry_t;

  // Next port index in round-robin order, wrapping at N_PORTS (not at 2**PORT_ID_WIDTH).
  function automatic port_idx_t rr_next(input port_idx_t idx);
    return (idx == port_idx_t'(N_PORTS - 1)) ? '0 : idx + 1'b1;
  endfunction

endpackage

// File: rtl/rab_miss_fifo.sv
// Small synchronous FIFO of miss entries; the head is read straight from storage
// and forced to zero while empty.
module rab_miss_fifo
  import rab_miss_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        push_i,
  input  miss_entry_t push_entry_i,
  input  logic        pop_i,
  output logic        full_o,
  output logic        empty_o,
  output miss_entry_t head_o
);

  logic [PTR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_WIDTH-1:0] count_q, count_d;
  miss_entry_t          mem_q [FIFO_DEPTH];
  logic                 do_push, do_pop;

  assign full_o  = (count_q == CNT_WIDTH'(FIFO_DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    count_d = count_q + CNT_WIDTH'(do_push) - CNT_WIDTH'(do_pop);
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is not reset; count_q gates every read, so stale data is never visible.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_entry_i;
  end

  assign head_o = empty_o ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/rab_miss_arbiter.sv
// Round-robin collector of per-port RAB misses into a small FIFO for software readout.
// Optional saturating lost-miss counter enabled by defining RAB_MISS_LOST_CNT_EN.
module rab_miss_arbiter
  import rab_miss_pkg::*;
(
  input  logic                                    s_axi_aclk,
  input  logic                                    s_axi_areset,
`ifdef RAB_MISS_LOST_CNT_EN
  input  logic                                    lost_cnt_clr_i,
  output logic [15:0]                             lost_cnt_o,
`endif
  input  logic [N_PORTS-1:0]                      miss_valid_i,
  input  logic [N_PORTS*ADDR_WIDTH-1:0]           miss_addr_i,
  input  logic [N_PORTS*C_AXI_ID_WIDTH-1:0]       miss_id_i,
  output logic                                    miss_valid_o,
  output logic [ADDR_WIDTH-1:0]                   miss_addr_o,
  output logic [PORT_ID_WIDTH+C_AXI_ID_WIDTH-1:0] miss_id_o,
  input  logic                                    miss_pop_i,
  output logic                                    fifo_full_o,
  output logic [N_PORTS-1:0]                      miss_lost_o
);

  logic [N_PORTS-1:0]        pend_q, pend_d;
  logic [ADDR_WIDTH-1:0]     slot_addr_q [N_PORTS];
  logic [ADDR_WIDTH-1:0]     slot_addr_d [N_PORTS];
  logic [C_AXI_ID_WIDTH-1:0] slot_id_q   [N_PORTS];
  logic [C_AXI_ID_WIDTH-1:0] slot_id_d   [N_PORTS];
  logic [N_PORTS-1:0]        lost_q, lost_d;
  port_idx_t                 rr_q, rr_d;

  port_idx_t   grant_idx, search_idx;
  logic        grant_valid;
  logic        fifo_full, fifo_empty;
  miss_entry_t push_entry, head;

  // Full is taken from the registered count, so a same-cycle pop never frees a slot for a push.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    search_idx  = rr_q;
    for (int i = 0; i < N_PORTS; i++) begin
      if (!fifo_full && !grant_valid && pend_q[search_idx]) begin
        grant_valid = 1'b1;
        grant_idx   = search_idx;
      end
      search_idx = rr_next(search_idx);
    end
    push_entry = '{port: grant_idx, id: slot_id_q[grant_idx], addr: slot_addr_q[grant_idx]};
    rr_d       = grant_valid ? rr_next(grant_idx) : rr_q;
  end

  // A slot freed by this cycle's grant can capture a new pulse in the same cycle.
  always_comb begin
    pend_d      = pend_q;
    slot_addr_d = slot_addr_q;
    slot_id_d   = slot_id_q;
    lost_d      = '0;
    if (grant_valid) pend_d[grant_idx] = 1'b0;
    for (int p = 0; p < N_PORTS; p++) begin
      if (miss_valid_i[p]) begin
        if (!pend_d[p]) begin
          pend_d[p]      = 1'b1;
          slot_addr_d[p] = miss_addr_i[p*ADDR_WIDTH +: ADDR_WIDTH];
          slot_id_d[p]   = miss_id_i[p*C_AXI_ID_WIDTH +: C_AXI_ID_WIDTH];
        end else begin
          lost_d[p] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge s_axi_aclk) begin
    if (s_axi_areset) begin
      pend_q <= '0;
      lost_q <= '0;
      rr_q   <= '0;
      for (int p = 0; p < N_PORTS; p++) begin
        slot_addr_q[p] <= '0;
        slot_id_q[p]   <= '0;
      end
    end else begin
      pend_q      <= pend_d;
      lost_q      <= lost_d;
      rr_q        <= rr_d;
      slot_addr_q <= slot_addr_d;
      slot_id_q   <= slot_id_d;
    end
  end

  rab_miss_fifo u_fifo (
    .clk          (s_axi_aclk),
    .rst          (s_axi_areset),
    .push_i       (grant_valid),
    .push_entry_i (push_entry),
    .pop_i        (miss_pop_i),
    .full_o       (fifo_full),
    .empty_o      (fifo_empty),
    .head_o       (head)
  );

  assign miss_valid_o = !fifo_empty;
  assign miss_addr_o  = head.addr;
  assign miss_id_o    = {head.port, head.id};
  assign fifo_full_o  = fifo_full;
  assign miss_lost_o  = lost_q;

`ifdef RAB_MISS_LOST_CNT_EN
  logic [15:0] lost_cnt_q, lost_cnt_d;
  logic [16:0] lost_sum;

  // Counts the registered lost pulses; clear wins over a same-cycle increment.
  always_comb begin
    lost_sum = {1'b0, lost_cnt_q};
    for (int p = 0; p < N_PORTS; p++) lost_sum = lost_sum + 17'(lost_q[p]);
    if (lost_cnt_clr_i)   lost_cnt_d = '0;
    else if (lost_sum[16]) lost_cnt_d = 16'hFFFF;
    else                   lost_cnt_d = lost_sum[15:0];
  end

  always_ff @(posedge s_axi_aclk) begin
    if (s_axi_areset) lost_cnt_q <= '0;
    else              lost_cnt_q <= lost_cnt_d;
  end

  assign lost_cnt_o = lost_cnt_q;
`endif

endmodule

// File: tb/tb_rab_miss_arbiter.sv
// Self-checking bench for rab_miss_arbiter: a queue-based reference model scores
// every cycle, plus directed checks for latency, fairness, full, push+pop and reset.
module tb_rab_miss_arbiter;

  typedef struct packed {
    logic [1:0]  port;
    logic [7:0]  id;
    logic [31:0] addr;
  } ent_t;

  logic        clk = 1'b0;
  logic        s_axi_areset;
  logic [2:0]  miss_valid_i;
  logic [95:0] miss_addr_i;
  logic [23:0] miss_id_i;
  logic        miss_valid_o;
  logic [31:0] miss_addr_o;
  logic [9:0]  miss_id_o;
  logic        miss_pop_i;
  logic        fifo_full_o;
  logic [2:0]  miss_lost_o;
`ifdef RAB_MISS_LOST_CNT_EN
  logic        lost_cnt_clr_i;
  logic [15:0] lost_cnt_o;
`endif

  always #5 clk = ~clk;

  rab_miss_arbiter dut (
    .s_axi_aclk     (clk),
    .s_axi_areset   (s_axi_areset),
`ifdef RAB_MISS_LOST_CNT_EN
    .lost_cnt_clr_i (lost_cnt_clr_i),
    .lost_cnt_o     (lost_cnt_o),
`endif
    .miss_valid_i   (miss_valid_i),
    .miss_addr_i    (miss_addr_i),
    .miss_id_i      (miss_id_i),
    .miss_valid_o   (miss_valid_o),
    .miss_addr_o    (miss_addr_o),
    .miss_id_o      (miss_id_o),
    .miss_pop_i     (miss_pop_i),
    .fifo_full_o    (fifo_full_o),
    .miss_lost_o    (miss_lost_o)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Stimulus values for the next cycle, per port
  logic [31:0] a_in [3];
  logic [7:0]  i_in [3];
  logic        clr_in = 1'b0;

  // Reference model state
  ent_t       m_q [$];
  bit   [2:0] m_pend;
  logic [31:0] m_saddr [3];
  logic [7:0]  m_sid [3];
  int         m_rr;
  bit   [2:0] m_lost;
  int         m_lcnt;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Advance the model by one clock edge using the inputs that were just sampled.
  function automatic void model_edge();
    int g;
    bit [2:0] old_lost;
    int pc;
    if (s_axi_areset) begin
      m_q.delete();
      m_pend = '0;
      m_rr   = 0;
      m_lost = '0;
      m_lcnt = 0;
      return;
    end
    old_lost = m_lost;
    pc = int'(old_lost[0]) + int'(old_lost[1]) + int'(old_lost[2]);
    if (clr_in) m_lcnt = 0;
    else        m_lcnt = (m_lcnt + pc > 65535) ? 65535 : m_lcnt + pc;
    g = -1;
    if (m_q.size() < 4) begin
      for (int i = 0; i < 3; i++) begin
        int j;
        j = (m_rr + i) % 3;
        if (g < 0 && m_pend[j]) g = j;
      end
    end
    if (miss_pop_i && m_q.size() > 0) void'(m_q.pop_front());
    if (g >= 0) begin
      m_q.push_back('{port: 2'(g), id: m_sid[g], addr: m_saddr[g]});
      m_pend[g] = 1'b0;
      m_rr = (g + 1) % 3;
    end
    m_lost = '0;
    for (int p = 0; p < 3; p++) begin
      if (miss_valid_i[p]) begin
        if (!m_pend[p]) begin
          m_pend[p]  = 1'b1;
          m_saddr[p] = a_in[p];
          m_sid[p]   = i_in[p];
        end else begin
          m_lost[p] = 1'b1;
        end
      end
    end
  endfunction

  task automatic compare_all();
    ent_t e;
    e = '0;
    if (m_q.size() > 0) e = m_q[0];
    check("valid", miss_valid_o, m_q.size() != 0);
    check("addr", miss_addr_o, e.addr);
    check("id", miss_id_o, {e.port, e.id});
    check("full", fifo_full_o, m_q.size() == 4);
    check("lost", miss_lost_o, m_lost);
`ifdef RAB_MISS_LOST_CNT_EN
    check("lost_cnt", lost_cnt_o, 16'(m_lcnt));
`endif
  endtask

  task automatic set_auto();
    for (int p = 0; p < 3; p++) begin
      a_in[p] = 32'h2000_0000 + (32'(cyc) << 8) + 32'(p * 4);
      i_in[p] = 8'(cyc * 7 + p);
    end
  endtask

  // One clock: drive, let the edge happen, update the model, compare #1 later.
  task automatic cycle(input logic [2:0] v, input logic pop);
    miss_valid_i = v;
    miss_pop_i   = pop;
    for (int p = 0; p < 3; p++) begin
      miss_addr_i[p*32 +: 32] = a_in[p];
      miss_id_i[p*8 +: 8]     = i_in[p];
    end
`ifdef RAB_MISS_LOST_CNT_EN
    lost_cnt_clr_i = clr_in;
`endif
    @(posedge clk);
    model_edge();
    #1;
    cyc++;
    compare_all();
    miss_valid_i = '0;
    miss_pop_i   = 1'b0;
  endtask

  // Reset cycle also carries pulses and a pop, which must be ignored.
  task automatic do_reset();
    s_axi_areset = 1'b1;
    set_auto();
    cycle(3'b111, 1'b1);
    s_axi_areset = 1'b0;
  endtask

  task automatic fill_four();
    set_auto();
    cycle(3'b001, 1'b0);
    set_auto();
    cycle(3'b010, 1'b0);
    set_auto();
    cycle(3'b001, 1'b0);
    set_auto();
    cycle(3'b010, 1'b0);
    cycle(3'b000, 1'b0);
    cycle(3'b000, 1'b0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] saved_addr;
    logic [1:0]  seen_port [$];
    logic [31:0] seen_addr [$];
    int          order [$];

    s_axi_areset = 1'b0;
    miss_valid_i = '0;
    miss_pop_i   = 1'b0;
    miss_addr_i  = '0;
    miss_id_i    = '0;
`ifdef RAB_MISS_LOST_CNT_EN
    lost_cnt_clr_i = 1'b0;
`endif
    m_pend = '0;
    m_rr   = 0;
    m_lost = '0;
    m_lcnt = 0;
    #1;
    do_reset();
    check("rst_valid", miss_valid_o, 1'b0);
    check("rst_full", fifo_full_o, 1'b0);
    check("rst_lost", miss_lost_o, 3'b000);

    // Single miss: latency 2, then pop empties
    a_in[1] = 32'h1000_0040;
    i_in[1] = 8'h05;
    cycle(3'b010, 1'b0);
    check("single_t1_valid", miss_valid_o, 1'b0);
    cycle(3'b000, 1'b0);
    check("single_t2_valid", miss_valid_o, 1'b1);
    check("single_addr", miss_addr_o, 32'h1000_0040);
    check("single_id", miss_id_o, 10'h105);
    cycle(3'b000, 1'b1);
    check("single_pop_empty", miss_valid_o, 1'b0);
    check("single_pop_addr", miss_addr_o, 32'h0);

    // Fairness: all ports pulse every cycle, pop whenever head is valid
    do_reset();
    for (int k = 0; k < 15; k++) begin
      logic p;
      set_auto();
      p = miss_valid_o;
      if (p) order.push_back(int'(miss_id_o[9:8]));
      cycle(3'b111, p);
    end
    for (int k = 0; k < 8; k++) begin
      logic p;
      p = miss_valid_o;
      if (p) order.push_back(int'(miss_id_o[9:8]));
      cycle(3'b000, p);
    end
    check("rr_count", order.size() >= 12, 1'b1);
    for (int i = 0; i < order.size(); i++) check("rr_order", order[i], i % 3);

    // Full: four entries, then port 2 pulses twice
    do_reset();
    fill_four();
    check("full_set", fifo_full_o, 1'b1);
    set_auto();
    saved_addr = a_in[2];
    cycle(3'b100, 1'b0);
    set_auto();
    cycle(3'b100, 1'b0);
    check("full_lost2", miss_lost_o, 3'b100);
    cycle(3'b000, 1'b1);
    check("full_after_pop", fifo_full_o, 1'b0);
    cycle(3'b000, 1'b0);
    check("full_refill", fifo_full_o, 1'b1);
    for (int k = 0; k < 4; k++) begin
      seen_port.push_back(miss_id_o[9:8]);
      seen_addr.push_back(miss_addr_o);
      cycle(3'b000, 1'b1);
    end
    check("full_4th_port", seen_port[3], 2'd2);
    check("full_4th_addr", seen_addr[3], saved_addr);
    check("full_drained", miss_valid_o, 1'b0);

    // Simultaneous push and pop with one entry held
    do_reset();
    set_auto();
    cycle(3'b001, 1'b0);
    cycle(3'b000, 1'b0);
    set_auto();
    cycle(3'b010, 1'b0);
    cycle(3'b000, 1'b1);
    check("pp_valid", miss_valid_o, 1'b1);
    check("pp_port", miss_id_o[9:8], 2'd1);
    cycle(3'b000, 1'b1);
    check("pp_count_one", miss_valid_o, 1'b0);

    // Reset mid-operation: three buffered plus a pending slot
    do_reset();
    set_auto();
    cycle(3'b111, 1'b0);
    cycle(3'b000, 1'b0);
    cycle(3'b000, 1'b0);
    cycle(3'b000, 1'b0);
    set_auto();
    cycle(3'b001, 1'b0);
    do_reset();
    check("mid_rst_valid", miss_valid_o, 1'b0);
    check("mid_rst_addr", miss_addr_o, 32'h0);
    check("mid_rst_id", miss_id_o, 10'h0);
    check("mid_rst_full", fifo_full_o, 1'b0);
    check("mid_rst_lost", miss_lost_o, 3'b000);
    set_auto();
    cycle(3'b010, 1'b0);
    check("mid_rst_t1", miss_valid_o, 1'b0);
    cycle(3'b000, 1'b0);
    check("mid_rst_t2", miss_valid_o, 1'b1);
    check("mid_rst_port", miss_id_o[9:8], 2'd1);

    // Random traffic: low pop rate then high pop rate
    for (int k = 0; k < 400; k++) begin
      logic p;
      set_auto();
      p = (k < 200) ? (($urandom % 4) == 0) : (($urandom % 4) != 0);
      cycle(3'($urandom_range(0, 7)), p);
    end

`ifdef RAB_MISS_LOST_CNT_EN
    do_reset();
    fill_four();
    set_auto();
    cycle(3'b111, 1'b0);
    set_auto();
    cycle(3'b111, 1'b0);
    cycle(3'b000, 1'b0);
    check("lcnt_plus3", lost_cnt_o, 16'd3);
    for (int k = 0; k < 21860; k++) cycle(3'b111, 1'b0);
    check("lcnt_sat", lost_cnt_o, 16'hFFFF);
    clr_in = 1'b1;
    cycle(3'b111, 1'b0);
    clr_in = 1'b0;
    check("lcnt_clr", lost_cnt_o, 16'h0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
